// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - shared condition-code and flag definitions for the execute stage
// Purpose: condition-field encodings, NZCV bit positions and the flag vector type.
// Ports: none (package).
package cond_pkg;

  // ARM condition field encodings.
  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_t;

  // Bit positions inside the {N,Z,C,V} flag vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] flags_t;

endpackage

// File: rtl/cond_unit_if.sv
// rtl/cond_unit_if.sv - execute-stage control/flag bundle between pipeline and cond_unit
// Purpose: groups the execute-stage controls, ALU flags and the gated results.
// Ports (signals):
//   to cond_unit   : StallE, FlushE, CondE[3:0], FlagWriteE[1:0], PCSE, RegWE,
//                    MemWE, NoWriteE, ALUFlags[3:0]
//   from cond_unit : CondExE, PCSrcE, RegWriteE, MemWriteE, Flags[3:0], Carry, UndefE
// Modports: master = pipeline side, slave = cond_unit.
interface cond_unit_if;

  logic                StallE;
  logic                FlushE;
  logic [3:0]          CondE;
  logic [1:0]          FlagWriteE;
  logic                PCSE;
  logic                RegWE;
  logic                MemWE;
  logic                NoWriteE;
  cond_pkg::flags_t    ALUFlags;

  logic                CondExE;
  logic                PCSrcE;
  logic                RegWriteE;
  logic                MemWriteE;
  cond_pkg::flags_t    Flags;
  logic                Carry;
  logic                UndefE;

  modport master (
    output StallE, FlushE, CondE, FlagWriteE, PCSE, RegWE, MemWE, NoWriteE, ALUFlags,
    input  CondExE, PCSrcE, RegWriteE, MemWriteE, Flags, Carry, UndefE
  );

  modport slave (
    input  StallE, FlushE, CondE, FlagWriteE, PCSE, RegWE, MemWE, NoWriteE, ALUFlags,
    output CondExE, PCSrcE, RegWriteE, MemWriteE, Flags, Carry, UndefE
  );

endinterface

// File: rtl/cond_check.sv
// rtl/cond_check.sv - combinational ARM condition-field evaluator
// Purpose: decides whether a condition field passes against a flag vector.
// Ports:
//   CondE [3:0] in  : condition field
//   Flags [3:0] in  : {N,Z,C,V}
//   cond        out : 1 when the condition holds
module cond_check
  import cond_pkg::*;
#(
  parameter bit UNDEF_KILL = 1'b1
) (
  input  logic [3:0] CondE,
  input  flags_t     Flags,
  output logic       cond
);

  logic n, z, c, v;

  always_comb begin
    n    = Flags[FLAG_N];
    z    = Flags[FLAG_Z];
    c    = Flags[FLAG_C];
    v    = Flags[FLAG_V];
    cond = 1'b0;
    case (cond_t'(CondE))
      EQ:      cond = z;
      NE:      cond = ~z;
      CS:      cond = c;
      CC:      cond = ~c;
      MI:      cond = n;
      PL:      cond = ~n;
      VS:      cond = v;
      VC:      cond = ~v;
      HI:      cond = c & ~z;
      LS:      cond = ~c | z;
      GE:      cond = (n == v);
      LT:      cond = (n != v);
      GT:      cond = ~z & (n == v);
      LE:      cond = z | (n != v);
      AL:      cond = 1'b1;
      NV:      cond = ~UNDEF_KILL;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - execute-stage condition gate and architectural NZCV register
// Purpose: holds NZCV, evaluates the condition on the registered flags and gates
//          the stage's PC/register/memory write controls with the result.
// Ports:
//   clk   in : rising-edge clock
//   reset in : synchronous active-high reset
//   bus      : cond_unit_if.slave (controls in, gated controls/flags out)
module cond_unit
  import cond_pkg::*;
#(
  parameter flags_t RESET_FLAGS = 4'b0000,
  parameter bit     UNDEF_KILL  = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  cond_unit_if.slave     bus
);

  flags_t flags_q, flags_d;
  logic   cond;
  logic   pass;

  // Evaluated on the registered flags only, so a producer's ALUFlags never
  // influence its own condition and no path exists from ALUFlags to Carry.
  cond_check #(.UNDEF_KILL(UNDEF_KILL)) u_cond_check (
    .CondE (bus.CondE),
    .Flags (flags_q),
    .cond  (cond)
  );

  assign pass = cond & ~bus.FlushE;

  always_comb begin
    flags_d = flags_q;
    // Stall blocks only the flag write; the gated outputs below stay live.
    if (!bus.StallE && pass) begin
      if (bus.FlagWriteE[1]) flags_d[3:2] = bus.ALUFlags[3:2];
      if (bus.FlagWriteE[0]) flags_d[1:0] = bus.ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) flags_q <= RESET_FLAGS;
    else       flags_q <= flags_d;
  end

  assign bus.CondExE   = pass;
  assign bus.PCSrcE    = bus.PCSE & pass;
  assign bus.RegWriteE = bus.RegWE & ~bus.NoWriteE & pass;
  assign bus.MemWriteE = bus.MemWE & pass;
  assign bus.UndefE    = (bus.CondE == 4'b1111) & ~bus.FlushE;
  assign bus.Flags     = flags_q;
  assign bus.Carry     = flags_q[FLAG_C];

endmodule

// File: tb/tb_cond_unit.sv
// tb/tb_cond_unit.sv - scoreboard bench for cond_unit
module tb_cond_unit;
  import cond_pkg::*;

  localparam logic [3:0] RST_F = 4'b0000;
  localparam bit         UK    = 1'b1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cond_unit_if bus ();

  cond_unit #(.RESET_FLAGS(RST_F), .UNDEF_KILL(UK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       condex;
    logic       pcsrc;
    logic       regw;
    logic       memw;
    logic       undef;
    logic [3:0] flags;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] model_flags;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cc, v;
    n = f[3]; z = f[2]; cc = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cc;
      4'h3: return !cc;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cc && !z;
      4'h9: return !cc || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return !UK;
    endcase
  endfunction

  // Called just after a rising edge: drive one cycle, queue its expectation,
  // then advance the flag model across the next edge.
  task automatic step(input logic [3:0] c, input logic [1:0] fw, input logic pcs,
                      input logic rw, input logic mw, input logic nw, input logic st,
                      input logic fl, input logic rs, input logic [3:0] alu);
    exp_t e;
    logic p;
    reset          = rs;
    bus.CondE      = c;
    bus.FlagWriteE = fw;
    bus.PCSE       = pcs;
    bus.RegWE      = rw;
    bus.MemWE      = mw;
    bus.NoWriteE   = nw;
    bus.StallE     = st;
    bus.FlushE     = fl;
    bus.ALUFlags   = alu;
    p        = cond_ok(c, model_flags) && !fl;
    e.condex = p;
    e.pcsrc  = pcs && p;
    e.regw   = rw && !nw && p;
    e.memw   = mw && p;
    e.undef  = (c == 4'hF) && !fl;
    e.flags  = model_flags;
    sb.push_back(e);
    @(posedge clk);
    if (rs) model_flags = RST_F;
    else if (!st && p) begin
      if (fw[1]) model_flags[3:2] = alu[3:2];
      if (fw[0]) model_flags[1:0] = alu[1:0];
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check("CondExE",   bus.CondExE,   e.condex);
      check("PCSrcE",    bus.PCSrcE,    e.pcsrc);
      check("RegWriteE", bus.RegWriteE, e.regw);
      check("MemWriteE", bus.MemWriteE, e.memw);
      check("UndefE",    bus.UndefE,    e.undef);
      check("Flags",     bus.Flags,     e.flags);
      check("Carry",     bus.Carry,     e.flags[1]);
    end
  end

  initial begin
    reset          = 1'b1;
    bus.StallE     = 1'b0;
    bus.FlushE     = 1'b0;
    bus.CondE      = AL;
    bus.FlagWriteE = 2'b11;
    bus.PCSE       = 1'b0;
    bus.RegWE      = 1'b0;
    bus.MemWE      = 1'b0;
    bus.NoWriteE   = 1'b0;
    bus.ALUFlags   = 4'hF;
    model_flags    = RST_F;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_Flags", bus.Flags, 4'b0000);
    check("rst_Carry", bus.Carry, 1'b0);
    @(posedge clk);
    #1;

    // After reset: EQ fails, NE passes.
    step(EQ, 2'b00, 1, 1, 1, 0, 0, 0, 0, 4'h0);
    step(NE, 2'b00, 1, 1, 1, 0, 0, 0, 0, 4'h0);

    // CMP-class: flags written, register write suppressed.
    step(AL, 2'b11, 0, 1, 0, 1, 0, 0, 0, 4'b0110);
    step(HI, 2'b00, 0, 1, 0, 0, 0, 0, 0, 4'h0);
    step(LS, 2'b00, 0, 1, 0, 0, 0, 0, 0, 4'h0);

    // Mid-operation reset, then split half writes.
    step(AL, 2'b11, 0, 0, 0, 0, 0, 0, 1, 4'hF);
    step(AL, 2'b10, 0, 0, 0, 0, 0, 0, 0, 4'b1111);
    step(AL, 2'b01, 0, 0, 0, 0, 0, 0, 0, 4'b0001);
    step(AL, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'h0);

    // Stall holds flags but outputs stay live; flush beats stall.
    step(AL, 2'b00, 0, 0, 0, 0, 0, 0, 1, 4'h0);
    repeat (3) step(AL, 2'b11, 1, 1, 1, 0, 1, 0, 0, 4'b1010);
    step(AL, 2'b11, 1, 1, 1, 0, 1, 1, 0, 4'b1010);
    step(AL, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'h0);

    // Signed conditions with N=V=1, then N=1,V=0.
    step(AL, 2'b11, 0, 0, 0, 0, 0, 0, 0, 4'b1001);
    step(GE, 2'b00, 1, 0, 0, 0, 0, 0, 0, 4'h0);
    step(GT, 2'b00, 1, 0, 0, 0, 0, 0, 0, 4'h0);
    step(LT, 2'b00, 1, 0, 0, 0, 0, 0, 0, 4'h0);
    step(LE, 2'b00, 1, 0, 0, 0, 0, 0, 0, 4'h0);
    step(AL, 2'b11, 0, 0, 0, 0, 0, 0, 0, 4'b1000);
    step(GE, 2'b00, 1, 0, 0, 0, 0, 0, 0, 4'h0);
    step(GT, 2'b00, 1, 0, 0, 0, 0, 0, 0, 4'h0);
    step(LT, 2'b00, 1, 0, 0, 0, 0, 0, 0, 4'h0);
    step(LE, 2'b00, 1, 0, 0, 0, 0, 0, 0, 4'h0);

    // NV: killed, undef flagged; flushed NV is not flagged.
    step(NV, 2'b11, 0, 1, 0, 0, 0, 0, 0, 4'b0101);
    step(NV, 2'b11, 0, 1, 0, 0, 0, 1, 0, 4'b0101);
    step(AL, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'h0);

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      step(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)));
    end

    @(negedge clk);
    #1;
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
